// File: rtl/shiftreg_pkg.sv
// Shared constants for the universal shift register: step-mode encodings
// and burst-engine FSM states.
package shiftreg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ASR  = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/shiftreg_step.sv
// Combinational single-step function of the register, shared by the manual
// Shift path and the burst engine.
module shiftreg_step
  import shiftreg_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] r,
  input  logic [2:0]      mode,
  input  logic            SerInLo,
  input  logic            SerInHi,
  output logic [SIZE-1:0] r_next
);

  // Select the next register value for the requested mode
  always_comb begin
    r_next = r;
    case (mode)
      MODE_HOLD: r_next = r;
      MODE_SHL:  r_next = {r[SIZE-2:0], SerInLo};
      MODE_SHR:  r_next = {SerInHi, r[SIZE-1:1]};
      MODE_ROL:  r_next = {r[SIZE-2:0], r[SIZE-1]};
      MODE_ROR:  r_next = {r[0], r[SIZE-1:1]};
      MODE_ASR:  r_next = {r[SIZE-1], r[SIZE-1:1]};
      default:   r_next = r;
    endcase
  end

endmodule

// File: rtl/shiftreg_univ.sv
// Universal shift register with parallel load, manual single steps and an
// autonomous N-step burst engine reporting completion with a Done pulse.
module shiftreg_univ
  import shiftreg_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Load,
  input  logic [SIZE-1:0]  DataIn,
  input  logic             Shift,
  input  logic             Start,
  input  logic [CNT_W-1:0] Len,
  input  logic [2:0]       Mode,
  input  logic             SerInLo,
  input  logic             SerInHi,
  output logic             SerOutHi,
  output logic             SerOutLo,
  output logic [SIZE-1:0]  DataOut,
  output logic             Busy,
  output logic             Done
);

  logic [SIZE-1:0]  data_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       mode_r;
  state_t           state_r;
  logic             done_r;
  logic [2:0]       step_mode;
  logic [SIZE-1:0]  step_next;

  // A running burst uses the mode latched at Start, never the live input
  always_comb begin
    if (state_r == ST_RUN) begin
      step_mode = mode_r;
    end else begin
      step_mode = Mode;
    end
  end

  shiftreg_step #(.SIZE(SIZE)) u_step (
    .r       (data_r),
    .mode    (step_mode),
    .SerInLo (SerInLo),
    .SerInHi (SerInHi),
    .r_next  (step_next)
  );

  // Register, burst counter and FSM; Load overrides and aborts any burst
  always_ff @(posedge Clk) begin
    if (Rst) begin
      data_r  <= '0;
      cnt_r   <= '0;
      mode_r  <= MODE_HOLD;
      state_r <= ST_IDLE;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (Load) begin
        data_r  <= DataIn;
        cnt_r   <= '0;
        state_r <= ST_IDLE;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (Start) begin
              if (Len != '0) begin
                mode_r  <= Mode;
                cnt_r   <= Len;
                state_r <= ST_RUN;
              end else begin
                done_r <= 1'b1;
              end
            end else if (Shift) begin
              data_r <= step_next;
            end else begin
              data_r <= data_r;
            end
          end
          ST_RUN: begin
            data_r <= step_next;
            cnt_r  <= cnt_r - CNT_W'(1);
            if (cnt_r == CNT_W'(1)) begin
              state_r <= ST_IDLE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_RUN;
            end
          end
          default: begin
            cnt_r   <= '0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign DataOut  = data_r;
  assign SerOutHi = data_r[SIZE-1];
  assign SerOutLo = data_r[0];
  assign Busy     = (state_r == ST_RUN);
  assign Done     = done_r;

endmodule

// File: tb/tb_shiftreg_univ.sv
// Self-checking bench: directed known-answer checks plus random stimulus
// scored cycle by cycle against an arithmetic reference model.
module tb_shiftreg_univ;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Load = 1'b0;
  logic [7:0] DataIn = 8'h00;
  logic       Shift = 1'b0;
  logic       Start = 1'b0;
  logic [3:0] Len = 4'h0;
  logic [2:0] Mode = 3'b000;
  logic       SerInLo = 1'b0;
  logic       SerInHi = 1'b0;
  logic       SerOutHi;
  logic       SerOutLo;
  logic [7:0] DataOut;
  logic       Busy;
  logic       Done;

  shiftreg_univ #(.SIZE(8), .CNT_W(4)) dut (
    .Clk(Clk), .Rst(Rst), .Load(Load), .DataIn(DataIn), .Shift(Shift),
    .Start(Start), .Len(Len), .Mode(Mode), .SerInLo(SerInLo),
    .SerInHi(SerInHi), .SerOutHi(SerOutHi), .SerOutLo(SerOutLo),
    .DataOut(DataOut), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [7:0] data;
    logic       busy;
    logic       done;
  } snap_t;

  snap_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc_no = 0;

  // Reference model state
  int         m_val = 0;
  bit         m_busy = 1'b0;
  int         m_rem = 0;
  int         m_mode = 0;
  bit         m_done = 1'b0;

  function automatic int ref_step(int r, int m, int lo, int hi);
    case (m)
      1:       return ((r * 2) + lo) % 256;
      2:       return (r / 2) + hi * 128;
      3:       return ((r * 2) % 256) + (r / 128);
      4:       return (r / 2) + (r % 2) * 128;
      5:       return (r / 2) + (r / 128) * 128;
      default: return r;
    endcase
  endfunction

  // Advance the model with the inputs about to be sampled, then clock once
  task automatic cyc();
    snap_t e;
    if (Rst) begin
      m_val = 0; m_busy = 0; m_rem = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (Load) begin
        m_val = int'(DataIn); m_busy = 0; m_rem = 0;
      end else if (!m_busy) begin
        if (Start) begin
          if (Len > 0) begin
            m_busy = 1; m_rem = int'(Len); m_mode = int'(Mode);
          end else begin
            m_done = 1;
          end
        end else if (Shift) begin
          m_val = ref_step(m_val, int'(Mode), int'(SerInLo), int'(SerInHi));
        end
      end else begin
        m_val = ref_step(m_val, m_mode, int'(SerInLo), int'(SerInHi));
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_busy = 0; m_done = 1;
        end
      end
    end
    e.data = m_val[7:0];
    e.busy = m_busy;
    e.done = m_done;
    @(posedge Clk);
    sb.push_back(e);
    cyc_no++;
    #1;
  endtask

  task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic idle_in();
    Rst = 0; Load = 0; Shift = 0; Start = 0;
  endtask

  task automatic do_load(logic [7:0] v);
    idle_in(); Load = 1; DataIn = v; cyc(); Load = 0;
  endtask

  task automatic do_start(logic [2:0] m, logic [3:0] n);
    idle_in(); Start = 1; Mode = m; Len = n; cyc(); Start = 0;
  endtask

  // Scoreboard monitor: every clocked cycle yields one expected snapshot
  initial begin
    snap_t e;
    forever begin
      @(negedge Clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if ({DataOut, Busy, Done, SerOutHi, SerOutLo} !==
            {e.data, e.busy, e.done, e.data[7], e.data[0]}) begin
          n_bad++;
          $display("FAIL sb cycle %0d: got data=%h busy=%b done=%b hi=%b lo=%b, expected data=%h busy=%b done=%b",
                   cyc_no, DataOut, Busy, Done, SerOutHi, SerOutLo, e.data, e.busy, e.done);
        end
      end
    end
  end

  initial begin
    logic [2:0] modes [6];
    logic [7:0] exps  [6];
    modes = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
    exps  = '{8'h2D, 8'h4B, 8'h2D, 8'h4B, 8'hCB, 8'h96};

    // Reset and load
    Rst = 1; cyc(); cyc(); Rst = 0;
    chk("reset data", DataOut, 8'h00);
    chk("reset busy/done", {6'd0, Busy, Done}, 8'h00);
    do_load(8'hA5);
    chk("load A5", DataOut, 8'hA5);
    chk("load serouts", {6'd0, SerOutHi, SerOutLo}, 8'h03);

    // Manual single steps
    for (int i = 0; i < 6; i++) begin
      do_load(8'h96);
      SerInLo = 1; SerInHi = 0; Mode = modes[i]; Shift = 1; cyc(); Shift = 0;
      chk($sformatf("manual mode %0d", modes[i]), DataOut, exps[i]);
    end

    // Burst ROL 3 from 0x81
    do_load(8'h81);
    do_start(3'd3, 4'd3);
    chk("burst busy E0", {7'd0, Busy}, 8'h01);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk($sformatf("burst busy/done E%0d", i), {6'd0, Busy, Done},
          (i == 3) ? 8'h01 : 8'h02);
    end
    chk("burst result", DataOut, 8'h0C);
    cyc();
    chk("burst done clears", {7'd0, Done}, 8'h00);

    // Rotate wraps past SIZE; serial input feeds a long shift
    do_load(8'h01);
    do_start(3'd4, 4'd9);
    repeat (9) cyc();
    chk("ROR 9 result", DataOut, 8'h80);
    chk("ROR 9 done", {7'd0, Done}, 8'h01);
    do_load(8'h00);
    SerInLo = 1;
    do_start(3'd1, 4'd8);
    repeat (8) cyc();
    chk("SHL 8 serial fill", DataOut, 8'hFF);

    // Zero-length burst
    do_load(8'h5A);
    do_start(3'd3, 4'd0);
    chk("len0 done/busy", {6'd0, Busy, Done}, 8'h01);
    chk("len0 data", DataOut, 8'h5A);
    cyc();
    chk("len0 done clears", {7'd0, Done}, 8'h00);

    // Start and Shift while busy are ignored
    do_load(8'h81);
    do_start(3'd3, 4'd3);
    Start = 1; Shift = 1; Mode = 3'd4; Len = 4'd7; cyc();
    Start = 0; Shift = 0;
    cyc(); cyc();
    chk("busy ignore done", {6'd0, Busy, Done}, 8'h01);
    chk("busy ignore data", DataOut, 8'h0C);

    // Load aborts a burst
    do_load(8'h81);
    do_start(3'd3, 4'd5);
    cyc();
    do_load(8'h3C);
    chk("abort load data", DataOut, 8'h3C);
    chk("abort load busy", {7'd0, Busy}, 8'h00);
    repeat (5) begin
      cyc();
      chk("abort load no done", {7'd0, Done}, 8'h00);
    end

    // Reset aborts a burst
    do_start(3'd3, 4'd5);
    cyc();
    Rst = 1; cyc(); Rst = 0;
    chk("abort rst outs", {DataOut}, 8'h00);
    chk("abort rst flags", {4'd0, Busy, Done, SerOutHi, SerOutLo}, 8'h00);
    repeat (5) begin
      cyc();
      chk("abort rst no done", {7'd0, Done}, 8'h00);
    end

    // Randomised traffic scored against the model
    for (int i = 0; i < 600; i++) begin
      Rst     = ($urandom_range(0, 79) == 0);
      Load    = ($urandom_range(0, 11) == 0);
      Start   = ($urandom_range(0, 5) == 0);
      Shift   = ($urandom_range(0, 2) == 0);
      Len     = 4'($urandom_range(0, 15));
      Mode    = 3'($urandom_range(0, 7));
      DataIn  = 8'($urandom_range(0, 255));
      SerInLo = 1'($urandom_range(0, 1));
      SerInHi = 1'($urandom_range(0, 1));
      cyc();
    end
    idle_in();

    repeat (3) @(negedge Clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shiftreg_univ.md
Name: shiftreg_univ

Overview:
Parametrised universal shift register: parallel load, six shift/rotate modes, two serial ports, plus an autonomous burst engine that performs N steps after a single Start. It replaces the plain load/shift-left register in serialiser and SPI-style datapaths, where a controller needs "shift N bits, tell me when done" without counting cycles itself.

Parameters:
SIZE, 8, register width in bits (>=2)
CNT_W, 4, width of burst length Len and internal down-counter (max burst 2^CNT_W-1)

Ports:
Clk  in  1  rising-edge clock
Rst  in  1  synchronous reset, active high
Load  in  1  parallel load of DataIn
DataIn  in  SIZE  parallel load data
Shift  in  1  manual single step using Mode (idle only)
Start  in  1  launch burst of Len steps using Mode
Len  in  CNT_W  burst length, sampled on Start
Mode  in  3  operation select (see Behaviour)
SerInLo  in  1  serial bit entering at LSB (SHL)
SerInHi  in  1  serial bit entering at MSB (SHR)
SerOutHi  out  1  register[SIZE-1]
SerOutLo  out  1  register[0]
DataOut  out  SIZE  register contents
Busy  out  1  burst in progress
Done  out  1  one-cycle pulse, burst complete

Behaviour:
- One clock (Clk); reset is synchronous and active-high (Rst). Reset: register=0, counter=0, FSM=IDLE, Busy=0, Done=0, so DataOut=0, SerOutHi=0, SerOutLo=0.
- Mode encoding (step function on register r): 000 HOLD; 001 SHL {r[SIZE-2:0],SerInLo}; 010 SHR {SerInHi,r[SIZE-1:1]}; 011 ROL {r[SIZE-2:0],r[SIZE-1]}; 100 ROR {r[0],r[SIZE-1:1]}; 101 ASR {r[SIZE-1],r[SIZE-1:1]}; 110/111 reserved = HOLD.
- Serial inputs sampled live at every stepping edge, never latched.
- Priority per edge: Rst > Load > Start (IDLE only) > burst step (RUN) > Shift (IDLE only) > hold.
- FSM IDLE:
  - Start with Len=N>0: latch Mode to mode_q, counter=N, go RUN, Busy=1. No shift on this edge.
  - Start with Len=0: stay IDLE; Done=1 next cycle; register unchanged.
  - Shift without Start: one step with current Mode.
- FSM RUN:
  - Each edge: one step with mode_q, counter-1.
  - Edge where counter==1: go IDLE, Busy=0, Done=1 for exactly one cycle; DataOut already holds the final value while Done=1.
  - Timing: Start sampled at edge E0 -> steps at E1..EN -> Busy high cycles E0..EN-1 -> Done high cycle after EN. Start-to-Done = N+1 edges.
- Start or Shift while Busy: ignored. Mode/Len changes while Busy: ignored, latched copies are used.
- Load at any time: register=DataIn. If RUN, burst is aborted: IDLE, Busy=0, counter=0, no Done.
- Load and Start in the same IDLE cycle: load wins, Start is dropped.
- Len > SIZE is legal: shifts keep going, rotates wrap modulo SIZE.
- Done is registered and low in every cycle except the completion pulse.
- Rst mid-burst: immediate return to reset state, no Done.

Decomposition:
- Package shiftreg_pkg: 3-bit mode constants (MODE_HOLD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR) and FSM state constants (ST_IDLE, ST_RUN).
- One combinational sub-module, shiftreg_step (SIZE parameter; inputs r, mode, SerInLo, SerInHi; output next r). Manual and burst paths share it.
- FSM, counter and register stay in shiftreg_univ.

Test Plan:
- Reset/load: Rst=1 -> DataOut=0x00, Busy=0, Done=0. Load DataIn=0xA5 -> DataOut=0xA5, SerOutHi=1, SerOutLo=1.
- Manual modes from 0x96 with SerInLo=1, SerInHi=0, one Shift each, reloading 0x96 between them:
  - SHL -> 0x2D
  - SHR -> 0x4B
  - ROL -> 0x2D
  - ROR -> 0x4B
  - ASR -> 0xCB
  - Mode=111 -> 0x96
- Burst: load 0x81, Start Mode=ROL Len=3 -> Busy high 3 cycles, Done pulse 4 edges after Start, DataOut=0x0C, Done=0 on the following cycle.
- Wrap and serial input: load 0x01, Start Mode=ROR Len=9 -> DataOut=0x80. Load 0x00, SerInLo held 1, Start SHL Len=8 -> DataOut=0xFF.
- Boundaries:
  - Start Len=0 -> Done pulse next cycle, Busy never high, DataOut unchanged.
  - Start during Busy, or Shift during Busy -> no effect on length or result.
- Aborts:
  - Load 0x3C mid-burst -> DataOut=0x3C, Busy=0, no Done.
  - Rst mid-burst -> all outputs 0, no Done.
